mos_calc_seq: RTL

//  Sequential, parametrised MOSFET drain-current (Id) and transconductance (gm) engine.

---
 rtl/mos_calc_seq_if.sv | 27 ++
 rtl/mos_calc_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mos_calc_seq_if.sv
// Bundle handshake for mos_calc_seq: one operand bundle in, one result bundle out.
interface mos_calc_seq_if #(
  parameter int N_CH  = 6,
  parameter int IN_W  = 3,
  parameter int OUT_W = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N_CH*IN_W-1:0]  vgs_in;
  logic [N_CH*IN_W-1:0]  vds_in;
  logic [N_CH*IN_W-1:0]  w_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [N_CH*OUT_W-1:0] id_out;
  logic [N_CH*OUT_W-1:0] gm_out;
  logic                  busy;

  modport master (
    output in_valid, vgs_in, vds_in, w_in, out_ready,
    input  in_ready, out_valid, id_out, gm_out, busy
  );

  modport slave (
    input  in_valid, vgs_in, vds_in, w_in, out_ready,
    output in_ready, out_valid, id_out, gm_out, busy
  );
endinterface

// File: rtl/mos_calc_seq.sv
// Serial MOSFET Id/gm engine: captures N_CH channels, runs them one per cycle
// through a shared two-stage datapath, and presents all results in one bundle.
module mos_calc_seq #(
  parameter int N_CH  = 6,
  parameter int IN_W  = 3,
  parameter int OUT_W = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  mos_calc_seq_if.slave bus
);
  localparam int CW    = 3*IN_W + 2;
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int EW    = CW + OUT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {CUTOFF, TRIODE, SAT} region_t;

  state_t state, state_nx;

  logic [N_CH*IN_W-1:0]  vgs_q, vds_q, w_q;
  logic [IDX_W-1:0]      idx;
  logic                  issue_done;
  logic                  issue;

  logic                  s1_valid;
  logic [IDX_W-1:0]      s1_idx;
  region_t               s1_region;
  logic [CW-1:0]         s1_id_num, s1_gm_num;

  logic                  s2_valid;
  logic [IDX_W-1:0]      s2_idx;
  logic [OUT_W-1:0]      s2_id, s2_gm;

  logic [N_CH*OUT_W-1:0] id_q, gm_q;

  region_t               c_region;
  logic [CW-1:0]         c_id_num, c_gm_num;

  function automatic logic [OUT_W-1:0] sat(input logic [CW-1:0] q);
    logic [EW-1:0] qe;
    logic [EW-1:0] mx;
    qe = EW'(q);
    mx = {{(EW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    if (qe > mx) return '1;
    else         return qe[OUT_W-1:0];
  endfunction

  assign issue         = (state == RUN) && !issue_done;
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.id_out    = id_q;
  assign bus.gm_out    = gm_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: RUN ends once the last channel sits in stage 1, so DRAIN
  // covers its stage-2 result being written into the slot array.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.in_valid) state_nx = RUN;
      RUN:   if (s1_valid && s1_idx == IDX_W'(N_CH-1)) state_nx = DRAIN;
      DRAIN: state_nx = DONE;
      DONE:  if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture and channel issue counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vgs_q      <= '0;
      vds_q      <= '0;
      w_q        <= '0;
      idx        <= '0;
      issue_done <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      vgs_q      <= bus.vgs_in;
      vds_q      <= bus.vds_in;
      w_q        <= bus.w_in;
      idx        <= '0;
      issue_done <= 1'b0;
    end else if (issue) begin
      if (idx == IDX_W'(N_CH-1)) issue_done <= 1'b1;
      else                       idx        <= idx + IDX_W'(1);
    end
  end

  // Region classification and numerator products for the issued channel
  always_comb begin
    logic [CW-1:0] vgs_e, vds_e, w_e, vov;
    vgs_e    = CW'(vgs_q[int'(idx)*IN_W +: IN_W]);
    vds_e    = CW'(vds_q[int'(idx)*IN_W +: IN_W]);
    w_e      = CW'(w_q[int'(idx)*IN_W +: IN_W]);
    vov      = (vgs_e >= CW'(1)) ? vgs_e - CW'(1) : '0;
    c_region = SAT;
    c_id_num = w_e * vov * vov;
    c_gm_num = CW'(2) * w_e * vov;
    if (vgs_e <= CW'(1)) begin
      c_region = CUTOFF;
      c_id_num = '0;
      c_gm_num = '0;
    end else if (vov > vds_e) begin
      c_region = TRIODE;
      c_id_num = w_e * (CW'(2) * vov * vds_e - vds_e * vds_e);
      c_gm_num = CW'(2) * w_e * vds_e;
    end
  end

  // Stage 1: register region and products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_idx    <= '0;
      s1_region <= CUTOFF;
      s1_id_num <= '0;
      s1_gm_num <= '0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_idx    <= idx;
        s1_region <= c_region;
        s1_id_num <= c_id_num;
        s1_gm_num <= c_gm_num;
      end
    end
  end

  // Stage 2: floor divide by 3 and clamp to the output range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_idx   <= '0;
      s2_id    <= '0;
      s2_gm    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_idx <= s1_idx;
        s2_id  <= (s1_region == CUTOFF) ? '0 : sat(s1_id_num / CW'(3));
        s2_gm  <= (s1_region == CUTOFF) ? '0 : sat(s1_gm_num / CW'(3));
      end
    end
  end

  // Result slots: keep last transaction's values until overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q <= '0;
      gm_q <= '0;
    end else if (s2_valid) begin
      id_q[int'(s2_idx)*OUT_W +: OUT_W] <= s2_id;
      gm_q[int'(s2_idx)*OUT_W +: OUT_W] <= s2_gm;
    end
  end
endmodule
